// File: rtl/m_len_lookup_arbiter.sv
// ----------------------------------------------------------------------------
// m_len_lookup_arbiter
//
// Shares the single link_id -> M-length lookup path among NUM_REQ requesters.
// A round-robin arbiter picks one requester at a time. Its link_id goes out as
// a one-cycle id_enable pulse. The M length is captured LOOKUP_LAT cycles later
// and returned on a valid/ready response channel. Only one request is in
// flight at a time. An out-of-range link_id is answered with an error
// response, and no lookup is issued for it.
//
// Ports
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   req_valid    per-requester lookup request
//   req_link_id  link_id of requester i in bits [6i+5:6i]
//   req_ready    one-hot accept pulse (combinational, IDLE only)
//   lk_id_enable one-cycle pulse to the lookup path
//   lk_link_id   link_id presented to the lookup path (held until next issue)
//   lk_m_len     M length returned by the lookup path
//   rsp_valid    response available
//   rsp_ready    consumer accepts response
//   rsp_req_idx  requester that owns the response
//   rsp_m_len    captured M length, 0 on error
//   rsp_err      link_id exceeded MAX_LINK_ID
//   busy         high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module m_len_lookup_arbiter #(
    parameter int         NUM_REQ     = 4,
    parameter int         LOOKUP_LAT  = 2,
    parameter logic [5:0] MAX_LINK_ID = 6'd47
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [6*NUM_REQ-1:0]   req_link_id,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   lk_id_enable,
    output logic [5:0]             lk_link_id,
    input  logic [12:0]            lk_m_len,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2:0]             rsp_req_idx,
    output logic [12:0]            rsp_m_len,
    output logic                   rsp_err,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] RR_INIT  = 3'(NUM_REQ - 1);
    localparam logic [3:0] LAT_INIT = 4'(LOOKUP_LAT);

    state_t      state_q, state_d;
    logic [2:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        lk_id_enable_q, lk_id_enable_d;
    logic [5:0]  lk_link_id_q, lk_link_id_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [2:0]  rsp_req_idx_q, rsp_req_idx_d;
    logic [12:0] rsp_m_len_q, rsp_m_len_d;
    logic        rsp_err_q, rsp_err_d;
    logic        busy_q, busy_d;

    // Requests padded to the architectural maximum of 8, so the arbiter can
    // index them with a plain 3-bit grant index.
    logic [7:0]  valid_ext;
    logic [5:0]  id_ext [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ext
            if (gi < NUM_REQ) begin : g_used
                assign valid_ext[gi] = req_valid[gi];
                assign id_ext[gi]    = req_link_id[6*gi +: 6];
            end else begin : g_pad
                assign valid_ext[gi] = 1'b0;
                assign id_ext[gi]    = 6'd0;
            end
        end
    endgenerate

    // Candidate index k positions after base, wrapping at NUM_REQ.
    function automatic logic [2:0] rr_next(input logic [2:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return 3'(s);
    endfunction

    // Round-robin search that starts just after the last winner.
    logic       grant_any;
    logic [2:0] grant_idx;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = rr_ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_any && valid_ext[rr_next(rr_ptr_q, k)]) begin
                grant_any = 1'b1;
                grant_idx = rr_next(rr_ptr_q, k);
            end
        end
    end

    // The accept pulse must be combinational so that valid&ready meet in the
    // grant cycle itself.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = (state_q == IDLE) && grant_any &&
                                   (grant_idx == 3'(gi));
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        cnt_d          = cnt_q;
        lk_id_enable_d = 1'b0;
        lk_link_id_d   = lk_link_id_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_req_idx_d  = rsp_req_idx_q;
        rsp_m_len_d    = rsp_m_len_q;
        rsp_err_d      = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    rr_ptr_d      = grant_idx;
                    rsp_req_idx_d = grant_idx;
                    if (id_ext[grant_idx] <= MAX_LINK_ID) begin
                        // id_enable is registered, so it is raised on entry
                        // to ISSUE and drops again when ISSUE is left.
                        state_d        = ISSUE;
                        lk_id_enable_d = 1'b1;
                        lk_link_id_d   = id_ext[grant_idx];
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_m_len_d = 13'd0;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = LAT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // A count of 1 marks the cycle that is LOOKUP_LAT cycles past
                // the ISSUE cycle. The data is valid here.
                if (cnt_q == 4'd1) begin
                    rsp_m_len_d = lk_m_len;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            rr_ptr_q       <= RR_INIT;
            cnt_q          <= 4'd0;
            lk_id_enable_q <= 1'b0;
            lk_link_id_q   <= 6'd0;
            rsp_valid_q    <= 1'b0;
            rsp_req_idx_q  <= 3'd0;
            rsp_m_len_q    <= 13'd0;
            rsp_err_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            cnt_q          <= cnt_d;
            lk_id_enable_q <= lk_id_enable_d;
            lk_link_id_q   <= lk_link_id_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_req_idx_q  <= rsp_req_idx_d;
            rsp_m_len_q    <= rsp_m_len_d;
            rsp_err_q      <= rsp_err_d;
            busy_q         <= busy_d;
        end
    end

    assign lk_id_enable = lk_id_enable_q;
    assign lk_link_id   = lk_link_id_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_req_idx  = rsp_req_idx_q;
    assign rsp_m_len    = rsp_m_len_q;
    assign rsp_err      = rsp_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_m_len_lookup_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for m_len_lookup_arbiter.
// Main instance: NUM_REQ=4, LOOKUP_LAT=2. It is checked every cycle against a
// transaction-level timestamp model. Two side instances use LOOKUP_LAT=1 and
// LOOKUP_LAT=15. lk_m_len is driven with the current cycle number, so a
// captured length shows which cycle it was sampled in.
// ----------------------------------------------------------------------------
module tb_m_len_lookup_arbiter;

    localparam int NR  = 4;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [12:0] lk_m_len;
    assign lk_m_len = cyc[12:0];

    // main DUT
    logic [NR-1:0]   req_valid = '0;
    logic [6*NR-1:0] req_link_id = '0;
    logic [NR-1:0]   req_ready;
    logic            lk_id_enable;
    logic [5:0]      lk_link_id;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [2:0]      rsp_req_idx;
    logic [12:0]     rsp_m_len;
    logic            rsp_err;
    logic            busy;

    m_len_lookup_arbiter #(.NUM_REQ(NR), .LOOKUP_LAT(LAT), .MAX_LINK_ID(6'd47)) u_dut (
        .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_link_id(req_link_id),
        .req_ready(req_ready), .lk_id_enable(lk_id_enable), .lk_link_id(lk_link_id),
        .lk_m_len(lk_m_len), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_req_idx(rsp_req_idx), .rsp_m_len(rsp_m_len), .rsp_err(rsp_err), .busy(busy)
    );

    // side DUTs: index 0 -> LOOKUP_LAT=1, index 1 -> LOOKUP_LAT=15
    logic [NR-1:0]   a_valid [2];
    logic [6*NR-1:0] a_id [2];
    logic [NR-1:0]   a_ready [2];
    logic            a_en [2];
    logic [5:0]      a_lk_id [2];
    logic            a_rv [2];
    logic            a_rr = 1'b1;
    logic [2:0]      a_idx [2];
    logic [12:0]     a_mlen [2];
    logic            a_err [2];
    logic            a_busy [2];

    initial begin
        a_valid[0] = '0; a_valid[1] = '0;
        a_id[0] = '0;    a_id[1] = '0;
    end

    m_len_lookup_arbiter #(.NUM_REQ(NR), .LOOKUP_LAT(1), .MAX_LINK_ID(6'd47)) u_lat1 (
        .clk(clk), .n_rst(n_rst), .req_valid(a_valid[0]), .req_link_id(a_id[0]),
        .req_ready(a_ready[0]), .lk_id_enable(a_en[0]), .lk_link_id(a_lk_id[0]),
        .lk_m_len(lk_m_len), .rsp_valid(a_rv[0]), .rsp_ready(a_rr),
        .rsp_req_idx(a_idx[0]), .rsp_m_len(a_mlen[0]), .rsp_err(a_err[0]), .busy(a_busy[0])
    );

    m_len_lookup_arbiter #(.NUM_REQ(NR), .LOOKUP_LAT(15), .MAX_LINK_ID(6'd47)) u_lat15 (
        .clk(clk), .n_rst(n_rst), .req_valid(a_valid[1]), .req_link_id(a_id[1]),
        .req_ready(a_ready[1]), .lk_id_enable(a_en[1]), .lk_link_id(a_lk_id[1]),
        .lk_m_len(lk_m_len), .rsp_valid(a_rv[1]), .rsp_ready(a_rr),
        .rsp_req_idx(a_idx[1]), .rsp_m_len(a_mlen[1]), .rsp_err(a_err[1]), .busy(a_busy[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one transaction at a time, described by timestamps.
    // A grant in cycle t gives the issue pulse in t+1. The response appears
    // in t+2+LAT and carries cycle number t+1+LAT. An illegal id gives a
    // response in t+1 instead. After the response handshake, the arbiter is
    // free again in the next cycle.
    // ------------------------------------------------------------------
    bit          m_free = 1'b1;
    int          m_rr = NR - 1;
    int          m_idx, m_id, m_issue, m_resp, m_cand;
    bit          m_legal, m_found;
    logic [12:0] m_mlen;
    logic [5:0]  exp_lk_id = 6'd0;
    logic [NR-1:0] exp_ready;
    bit          exp_busy, exp_en, exp_rv;

    always @(negedge clk) begin
        if (!n_rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_lk_id_enable", lk_id_enable, 0);
            chk("rst_lk_link_id", lk_link_id, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_req_idx", rsp_req_idx, 0);
            chk("rst_rsp_m_len", rsp_m_len, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_busy", busy, 0);
            m_free = 1'b1;
            m_rr = NR - 1;
            exp_lk_id = 6'd0;
        end else begin
            exp_ready = '0;
            exp_busy = !m_free;
            exp_en = 1'b0;
            exp_rv = 1'b0;
            if (m_free) begin
                m_found = 1'b0;
                for (int k = 1; k <= NR; k++) begin
                    m_cand = (m_rr + k) % NR;
                    if (!m_found && req_valid[m_cand]) begin
                        m_found = 1'b1;
                        m_idx = m_cand;
                    end
                end
                if (m_found) begin
                    exp_ready[m_idx] = 1'b1;
                    m_free = 1'b0;
                    m_rr = m_idx;
                    m_id = int'(req_link_id[6*m_idx +: 6]);
                    m_legal = (m_id <= 47);
                    m_issue = cyc + 1;
                    m_resp = m_legal ? cyc + 2 + LAT : cyc + 1;
                    m_mlen = m_legal ? 13'(cyc + 1 + LAT) : 13'd0;
                end
            end else begin
                if (m_legal && cyc == m_issue) begin
                    exp_en = 1'b1;
                    exp_lk_id = 6'(m_id);
                end
                if (cyc >= m_resp) exp_rv = 1'b1;
            end
            chk("req_ready", req_ready, exp_ready);
            chk("busy", busy, exp_busy);
            chk("lk_id_enable", lk_id_enable, exp_en);
            chk("lk_link_id", lk_link_id, exp_lk_id);
            chk("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                chk("rsp_req_idx", rsp_req_idx, m_idx);
                chk("rsp_m_len", rsp_m_len, m_mlen);
                chk("rsp_err", rsp_err, !m_legal);
                if (rsp_ready) m_free = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        req_valid = '0;
        n_rst = 1'b0;
        repeat (n) tick();
        n_rst = 1'b1;
    endtask

    task automatic set_id(input int i, input int id);
        req_link_id[6*i +: 6] = 6'(id);
    endtask

    task automatic wait_ready(input int i, output int gcyc);
        bit ok = 1'b0;
        gcyc = -1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1'b1;
                gcyc = cyc;
                break;
            end
        end
        chk("wait_ready_bound", ok, 1);
    endtask

    task automatic wait_any_grant(output int idx);
        bit ok = 1'b0;
        idx = -1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (|req_ready) begin
                ok = 1'b1;
                for (int k = 0; k < NR; k++) if (req_ready[k]) idx = k;
                break;
            end
        end
        chk("wait_grant_bound", ok, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_idle_bound", ok, 1);
        tick();
    endtask

    task automatic aux_run(input int k, input int lat, input int id);
        bit ok;
        int issue_cyc;
        a_id[k][5:0] = 6'(id);
        a_valid[k] = 4'b0001;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (a_ready[k][0]) begin ok = 1'b1; break; end
        end
        chk("aux_grant_bound", ok, 1);
        tick();
        a_valid[k] = '0;
        ok = 1'b0;
        issue_cyc = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (a_en[k]) begin ok = 1'b1; issue_cyc = cyc; break; end
        end
        chk("aux_issue_bound", ok, 1);
        chk("aux_lk_link_id", a_lk_id[k], id);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (a_rv[k]) begin ok = 1'b1; break; end
        end
        chk("aux_rsp_bound", ok, 1);
        chk(lat == 1 ? "lat1_m_len" : "lat15_m_len", a_mlen[k], 13'(issue_cyc + lat));
        chk("aux_rsp_err", a_err[k], 0);
        tick();
        tick();
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    int g, idx;

    initial begin
        // 1. single request, hand-computed timing
        do_reset(3);
        rsp_ready = 1'b1;
        set_id(0, 5);
        req_valid = 4'b0001;
        wait_ready(0, g);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("single_issue_pulse", lk_id_enable, 1);
        chk("single_issue_id", lk_link_id, 5);
        repeat (3) @(negedge clk);
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_idx", rsp_req_idx, 0);
        chk("single_rsp_m_len", rsp_m_len, 13'(g + 3));
        @(negedge clk);
        chk("single_back_idle", busy, 0);
        tick();

        // 2. round-robin with every requester active
        do_reset(2);
        for (int i = 0; i < NR; i++) set_id(i, $urandom_range(0, 47));
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            wait_any_grant(idx);
            chk("rr_order", idx, n % NR);
        end
        tick();
        req_valid = '0;
        wait_idle();

        // 3. back-pressure: last grant was 3, so requester 0 wins next
        rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) set_id(i, $urandom_range(0, 47));
        req_valid = 4'b1111;
        wait_ready(0, g);
        repeat (4) @(negedge clk);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_idx", rsp_req_idx, 0);
            chk("bp_rsp_m_len", rsp_m_len, 13'(g + 3));
            chk("bp_busy", busy, 1);
            chk("bp_no_ready", req_ready, 0);
            chk("bp_no_issue", lk_id_enable, 0);
        end
        tick();
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        wait_ready(1, g);
        tick();
        req_valid = '0;
        wait_idle();

        // 4. illegal link_id: error response one cycle after the grant
        set_id(3, 63);
        req_valid = 4'b1000;
        wait_ready(3, g);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("illegal_rsp_valid", rsp_valid, 1);
        chk("illegal_rsp_err", rsp_err, 1);
        chk("illegal_rsp_m_len", rsp_m_len, 0);
        chk("illegal_no_issue", lk_id_enable, 0);
        @(negedge clk);
        chk("illegal_back_idle", busy, 0);
        tick();

        // 5. reset during WAIT, then simultaneous requests 0 and 2
        set_id(1, 42);
        req_valid = 4'b0010;
        wait_ready(1, g);
        tick();
        req_valid = '0;
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_lk_link_id", lk_link_id, 0);
        chk("midrst_lk_id_enable", lk_id_enable, 0);
        chk("midrst_req_ready", req_ready, 0);
        repeat (2) tick();
        n_rst = 1'b1;
        set_id(0, 10);
        set_id(2, 20);
        req_valid = 4'b0101;
        wait_any_grant(idx);
        chk("post_rst_first_grant", idx, 0);
        tick();
        req_valid = 4'b0100;
        wait_ready(2, g);
        tick();
        req_valid = '0;
        wait_idle();

        // 6. randomized traffic checked against the model
        for (int t = 0; t < 500; t++) begin
            for (int i = 0; i < NR; i++)
                set_id(i, ($urandom_range(0, 5) == 0) ? $urandom_range(48, 63)
                                                      : $urandom_range(0, 47));
            req_valid = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();

        // 7. LOOKUP_LAT=1 and LOOKUP_LAT=15 builds
        for (int n = 0; n < 3; n++) begin
            aux_run(0, 1, $urandom_range(0, 47));
            aux_run(1, 15, $urandom_range(0, 47));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/m_len_lookup_arbiter.md
Name: m_len_lookup_arbiter

Overview:
- Shares the single link_id -> M-length lookup path (turbo_len index generator plus ROM) among NUM_REQ requesters.
- Round-robin arbitration selects one requester at a time.
- For the granted requester: issue a one-cycle id_enable pulse with its link_id, wait the fixed lookup latency, capture the 13-bit M length, and return it over a valid/ready response channel.
- Sits between the turbo encoder/decoder channel controllers and the lookup datapath.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- LOOKUP_LAT, 2: clock cycles from the lk_id_enable cycle to valid lk_m_len, 1..15.
- MAX_LINK_ID, 6'd47: highest legal link_id; larger values are rejected without a lookup.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester lookup request.
- req_link_id  in  6*NUM_REQ  link_id of requester i in bits [6i+5:6i].
- req_ready  out  NUM_REQ  one-hot accept pulse, one cycle.
- lk_id_enable  out  1  one-cycle pulse to the lookup path.
- lk_link_id  out  6  link_id presented to the lookup path.
- lk_m_len  in  13  M length returned by the lookup path.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_req_idx  out  3  index of the requester that owns the response.
- rsp_m_len  out  13  captured M length; 0 on error.
- rsp_err  out  1  link_id exceeded MAX_LINK_ID.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values, all asynchronous on n_rst low: state=IDLE; req_ready=0; lk_id_enable=0; lk_link_id=0; rsp_valid=0; rsp_req_idx=0; rsp_m_len=0; rsp_err=0; busy=0; rr_ptr=NUM_REQ-1 (so requester 0 wins first); wait counter=0.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, the grant g is the first asserted index searching from rr_ptr+1 upward, modulo NUM_REQ.
  - req_ready[g]=1 combinationally in that same cycle; a request is accepted when valid and ready are both high.
  - At the clock edge: latch req_link_id[g] and g; set rr_ptr=g.
  - If latched link_id <= MAX_LINK_ID, go to ISSUE. Otherwise go to RESP with rsp_err=1 and rsp_m_len=0; no lookup is issued.
  - With no request, stay in IDLE; req_ready=0.
- ISSUE:
  - Exactly one cycle with lk_id_enable=1 and lk_link_id=latched id.
  - Load counter=LOOKUP_LAT, then go to WAIT.
  - lk_link_id holds its value until the next ISSUE.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter equals 1, sample lk_m_len into rsp_m_len at the edge, set rsp_err=0, and go to RESP.
  - Net result: data is sampled LOOKUP_LAT cycles after the ISSUE cycle.
- RESP:
  - rsp_valid=1; rsp_req_idx, rsp_m_len and rsp_err stay stable until accepted.
  - On rsp_valid and rsp_ready, clear rsp_valid at the edge and return to IDLE.
  - rsp_ready while rsp_valid is low is ignored.
- Throughput:
  - Lookup path: minimum 1+1+LOOKUP_LAT+1 cycles per request, i.e. 5 at default.
  - Error path: 2 cycles.
  - Exactly one request is in flight; no pipelining.
- req_valid is ignored outside IDLE; req_ready stays 0.
- A requester that keeps req_valid high after acceptance is re-arbitrated on the next IDLE visit. Round-robin guarantees every active requester a grant within NUM_REQ grants.
- Simultaneous requests resolve only through the rr_ptr rotation.
- Deasserting req_valid in the same cycle as grant is legal; that request is still accepted.
- Reset mid-operation: any state returns to IDLE and a pending response is discarded. A lookup already in flight is abandoned; its lk_m_len is never sampled.
- busy = (state != IDLE).

Test Plan:
- Single request: req 0, link_id=5, LOOKUP_LAT=2 -> req_ready[0] in cycle 0, lk_id_enable in cycle 1 with lk_link_id=5, lk_m_len sampled at the end of cycle 3, rsp_valid in cycle 4 with rsp_req_idx=0 and rsp_m_len equal to the model value; rsp_ready held high -> IDLE in cycle 5.
- Round-robin: all 4 req_valid held high for 8 grants -> grant order 0,1,2,3,0,1,2,3; at most one req_ready per cycle.
- Back-pressure: rsp_ready=0 for 10 cycles -> rsp_valid, rsp_m_len and rsp_req_idx stable, busy=1, no req_ready and no lk_id_enable; release -> one handshake, then the next grant.
- Illegal id: link_id=63 with MAX_LINK_ID=47 -> no lk_id_enable; rsp_valid 1 cycle after grant with rsp_err=1 and rsp_m_len=0.
- Reset mid-WAIT: drop n_rst during WAIT -> all outputs 0 immediately; after release, req 0 and req 2 asserted together -> req 0 granted first.
- LOOKUP_LAT=1 and LOOKUP_LAT=15 builds: lk_m_len changed every cycle to the cycle number -> captured value equals the cycle number of the ISSUE cycle plus LOOKUP_LAT.
